// File: rtl/mul_div_pkg.sv
// Shared types and op-class helpers for the multi-cycle multiply/divide unit.
package mul_div_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } MulDivOp_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_CALC = 2'd1,
    DIV_CALC = 2'd2,
    DIV_FIX  = 2'd3
  } MulDivState_e;

  function automatic logic is_div(input MulDivOp_e op);
    return op[2];
  endfunction

  function automatic logic is_signed_a(input MulDivOp_e op);
    return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_signed_b(input MulDivOp_e op);
    return (op == MULH) || (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/restoring_divider.sv
// Unsigned restoring divider: one quotient bit per step, MSB first.
module restoring_divider #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  logic [W-1:0] dvs_q;
  logic [W:0]   shifted, diff;
  logic         ge;

  // Partial remainder stays below the divisor, so a successful subtract fits in W bits.
  assign shifted = {remainder, quotient[W-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign ge      = ~diff[W];

  always_ff @(posedge clk) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      dvs_q     <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      dvs_q     <= divisor;
    end else if (step) begin
      quotient  <= {quotient[W-2:0], ge};
      remainder <= ge ? diff[W-1:0] : shifted[W-1:0];
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle RISC-V M-extension unit: registered multiply, iterative restoring divide,
// Start/Busy/Done handshake with Flush abort.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int DATA_LENGTH = 32,
  parameter int EARLY_OUT   = 1
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic [2:0]             Op,
  input  logic [DATA_LENGTH-1:0] InputA,
  input  logic [DATA_LENGTH-1:0] InputB,
  input  logic                   Flush,
  output logic                   Busy,
  output logic                   Done,
  output logic [DATA_LENGTH-1:0] Result
);

  localparam int W  = DATA_LENGTH;
  localparam int CW = $clog2(W + 1);

  MulDivState_e state_q, state_n;
  MulDivOp_e    op_in, op_q;
  logic [W-1:0]  a_q, b_q, special_res_q, special_res_in;
  logic [CW-1:0] cnt_q;
  logic          qneg_q, rneg_q, special_q;
  logic          accept, sa, sb, div0, ovf, special_in, done_n;
  logic [W-1:0]  mag_a, mag_b, quo, rem, div_res, mul_res, res_n;
  logic [2*W-1:0] ea, eb, prod;

  assign op_in  = MulDivOp_e'(Op);
  assign accept = (state_q == IDLE) && Start && !Flush;
  assign Busy   = (state_q != IDLE);

  // Operand conditioning at accept time
  assign sa    = is_signed_a(op_in) && InputA[W-1];
  assign sb    = is_signed_b(op_in) && InputB[W-1];
  assign mag_a = sa ? -InputA : InputA;
  assign mag_b = sb ? -InputB : InputB;
  assign div0  = (InputB == '0);
  assign ovf   = is_signed_b(op_in) && (InputA == {1'b1, {(W-1){1'b0}}}) && (InputB == '1);
  assign special_in = div0 || ovf;
  assign special_res_in = div0 ? (op_in[1] ? InputA : '1)
                               : (op_in[1] ? '0 : InputA);

  // Low 2W bits of the (2W+1)-bit signed product are exact modulo 2^2W.
  assign ea      = {{W{is_signed_a(op_q) & a_q[W-1]}}, a_q};
  assign eb      = {{W{is_signed_b(op_q) & b_q[W-1]}}, b_q};
  assign prod    = ea * eb;
  assign mul_res = (op_q == MUL) ? prod[W-1:0] : prod[2*W-1:W];

  // Special cases are latched so the slow path (EARLY_OUT=0) ends with the same answer.
  assign div_res = special_q ? special_res_q
                 : op_q[1]   ? (rneg_q ? -rem : rem)
                             : (qneg_q ? -quo : quo);

  restoring_divider #(.W(W)) u_div (
    .clk      (Clock),
    .rst      (Reset),
    .load     (accept && is_div(op_in)),
    .step     (state_q == DIV_CALC),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quotient (quo),
    .remainder(rem)
  );

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    done_n  = 1'b0;
    res_n   = Result;
    case (state_q)
      IDLE: if (accept) begin
        if (!is_div(op_in)) state_n = MUL_CALC;
        else if (special_in && (EARLY_OUT != 0)) begin
          done_n = 1'b1;
          res_n  = special_res_in;
        end else state_n = DIV_CALC;
      end
      MUL_CALC: begin
        state_n = IDLE;
        done_n  = 1'b1;
        res_n   = mul_res;
      end
      DIV_CALC: if (cnt_q == CW'(1)) state_n = DIV_FIX;
      DIV_FIX: begin
        state_n = IDLE;
        done_n  = 1'b1;
        res_n   = div_res;
      end
      default: state_n = IDLE;
    endcase
    if (Flush) begin
      state_n = IDLE;
      done_n  = 1'b0;
      res_n   = Result;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Done          <= 1'b0;
      Result        <= '0;
      op_q          <= MUL;
      a_q           <= '0;
      b_q           <= '0;
      qneg_q        <= 1'b0;
      rneg_q        <= 1'b0;
      special_q     <= 1'b0;
      special_res_q <= '0;
      cnt_q         <= '0;
    end else begin
      Done   <= done_n;
      Result <= res_n;
      if (accept) begin
        op_q          <= op_in;
        a_q           <= InputA;
        b_q           <= InputB;
        qneg_q        <= sa ^ sb;
        rneg_q        <= sa;
        special_q     <= special_in;
        special_res_q <= special_res_in;
        cnt_q         <= CW'(W);
      end else if (state_q == DIV_CALC) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Parametrised, multi-cycle multiply/divide unit for the CoreCpu, the successor to the single-cycle ALU mul/div path.
- Multiply uses one registered product stage. Divide uses an iterative restoring divider, one quotient bit per cycle.
- The pipeline talks to it through a Start/Busy/Done handshake and can Flush it on redirect.
- Full RISC-V M-extension semantics, including DIVU/REMU, divide-by-zero and signed overflow, which the single-cycle path did not implement.

Parameters:
DATA_LENGTH, 32, operand/result width W (>=8, even)
EARLY_OUT, 1, 1: divide-by-zero and signed-overflow cases finish in 1 cycle; 0: they run the full iteration count with the same result

Ports:
Clock  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-high; clears all state
Start  in  1  request; accepted only when Busy=0
Op  in  3  MulDivOp_e: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7
InputA  in  W  rs1 operand, sampled on accept
InputB  in  W  rs2 operand, sampled on accept
Flush  in  1  abort in-flight operation
Busy  out  1  operation in flight
Done  out  1  one-cycle pulse, Result valid
Result  out  W  result, held until next Done

Behaviour:
Clock and reset:
- One clock (Clock). Reset is synchronous, active-high.
- Reset values: Busy=0, Done=0, Result=0, state=IDLE, all internal registers 0.
- Priority: Reset > Flush > Start.

States: IDLE, MUL_CALC, DIV_CALC, DIV_FIX.
- IDLE + Start: latch Op, A, B.
  - Mul ops go to MUL_CALC.
  - Div ops: special case with EARLY_OUT=1 goes to IDLE with Done; otherwise to DIV_CALC with counter=W.
- MUL_CALC: register the 2W-bit product, go to IDLE with Done.
- DIV_CALC: one restoring step per cycle, counter decrements; at counter==1 go to DIV_FIX.
- DIV_FIX: apply sign correction, go to IDLE with Done.

Latency (Start high in cycle t, Done high in cycle t+L):
- L=2 for mul ops.
- L=W+2 for normal div.
- L=1 for EARLY_OUT special cases.
- Busy high in cycles t+1 .. t+L-1; low in the Done cycle.
- Done is high for exactly 1 cycle. Result is updated in the same cycle Done rises.

Handshake:
- Start while Busy=1 is ignored.
- Start in the Done cycle is accepted; back-to-back throughput is L cycles per op.

Flush:
- Next cycle: state=IDLE, Busy=0, no Done for the aborted op, Result unchanged.
- Flush together with Start in IDLE: Start is dropped.

Reset mid-operation: next cycle all outputs are at reset values; no Done.

Arithmetic:
- MUL returns the low W bits; MULH, MULHSU and MULHU return the high W bits.
- MULHSU sign-extends A and zero-extends B to 2W+1 bits before multiplying.
- Signed divide works on magnitudes:
  - quotient negated iff signs differ;
  - remainder takes the sign of the dividend.
- Divide by zero: DIV/DIVU return all ones; REM/REMU return A.
- Signed overflow (A=most negative, B=-1): DIV returns A; REM returns 0.

Decomposition:
- Package mul_div_pkg holds:
  - typedef enum MulDivOp_e (3-bit, values above);
  - typedef enum MulDivState_e;
  - helper functions is_div(op), is_signed_a(op), is_signed_b(op).
- The op encoding constants are also added to Constants.vh for the decoder.
- Sub-module restoring_divider (unsigned, W-parameterised, load/step/remainder/quotient registers).
- Sign handling, multiply and the FSM stay in mul_div_unit.

Test Plan:
- MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF, Start at t -> Done at t+2, Result=0xFFFFFFFF. MUL with the same operands -> 0x00000001.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Done at t+34, Result=0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 0x0000000E.
- DIVU A=100, B=0 (EARLY_OUT=1) -> Done at t+1, Result=0xFFFFFFFF. REMU with the same operands -> 0x00000064. With EARLY_OUT=0 -> same values at t+34.
- DIV A=0x80000000, B=0xFFFFFFFF -> Result=0x80000000 at t+1. REM with the same operands -> 0x00000000.
- DIV started at t, Flush at t+10 -> Busy=0 at t+11, no Done through t+40, Result keeps prior value. A Start at t+11 (MUL 6*7) -> Done at t+13, Result=42.
- Start MULHU in the Done cycle of a prior DIV -> accepted, Done 2 cycles later. Start while Busy -> ignored. Reset at t+5 of a DIV -> Busy=0, Result=0, no Done.
